// File: rtl/accum_window_ctrl_pkg.sv
// Shared types and helpers for the convolution window accumulator.
// The saturating add is only referenced when ACC_SATURATE_EN is defined.
package accum_window_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StOut,
      StFin
   } state_e;

   localparam int unsigned AccWidthDefault = 32;
   localparam int unsigned TapsDefault     = 9;

   // Unsigned add clamped to 2^width-1; operands must already fit in width bits (width <= 64).
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned width);
      logic [64:0] sum;
      logic [64:0] max_val;
      sum     = {1'b0, a} + {1'b0, b};
      max_val = (65'd1 << width) - 65'd1;
      return (sum > max_val) ? max_val[63:0] : sum[63:0];
   endfunction

endpackage

// File: rtl/accum_window_ctrl_if.sv
// Job control plus product-in / window-sum-out handshake bundle for accum_window_ctrl.
interface accum_window_ctrl_if #(
   parameter int unsigned DATA_BITWIDTH = 8,
   parameter int unsigned ACC_WIDTH     = 32,
   parameter int unsigned WIN_CNT_WIDTH = 16
);

   logic                     start;
   logic [WIN_CNT_WIDTH-1:0] num_windows;
   logic                     busy;
   logic                     done;

   logic [DATA_BITWIDTH-1:0] din;
   logic                     din_valid;
   logic                     din_ready;

   logic [ACC_WIDTH-1:0]     dout;
   logic                     dout_valid;
   logic                     dout_ready;

   logic [WIN_CNT_WIDTH-1:0] win_idx;

   // Upstream/downstream side that drives the job and the data streams.
   modport master (
      output start, num_windows, din, din_valid, dout_ready,
      input  busy, done, din_ready, dout, dout_valid, win_idx
   );

   // The accumulator controller.
   modport slave (
      input  start, num_windows, din, din_valid, dout_ready,
      output busy, done, din_ready, dout, dout_valid, win_idx
   );

endinterface

// File: rtl/accum_window_ctrl_datapath.sv
// Partial-sum register and adder; wraps by default, saturates when ACC_SATURATE_EN is defined.
module accum_datapath
   import accum_window_ctrl_pkg::*;
#(
   parameter int unsigned DATA_BITWIDTH = 8,
   parameter int unsigned ACC_WIDTH     = AccWidthDefault
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     clr,
   input  logic                     en,
   input  logic [DATA_BITWIDTH-1:0] din,
   output logic [ACC_WIDTH-1:0]     psum
);

   logic [ACC_WIDTH-1:0] psum_q;
   logic [ACC_WIDTH-1:0] psum_d;
   logic [ACC_WIDTH-1:0] sum;

`ifdef ACC_SATURATE_EN
   assign sum = ACC_WIDTH'(sat_add(64'(psum_q), 64'(din), ACC_WIDTH));
`else
   assign sum = psum_q + ACC_WIDTH'(din);
`endif

   // clr wins over en so a new window never inherits a beat from the old one.
   always_comb begin
      psum_d = psum_q;
      if (clr) begin
         psum_d = '0;
      end else if (en) begin
         psum_d = sum;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         psum_q <= '0;
      end else begin
         psum_q <= psum_d;
      end
   end

   assign psum = psum_q;

endmodule

// File: rtl/accum_window_ctrl.sv
// Window sequencer: accumulates TAPS products per window over num_windows windows.
// Optional ACC_SATURATE_EN selects saturating accumulation inside accum_datapath.
module accum_window_ctrl
   import accum_window_ctrl_pkg::*;
#(
   parameter int unsigned DATA_BITWIDTH = 8,
   parameter int unsigned ACC_WIDTH     = AccWidthDefault,
   parameter int unsigned TAPS          = TapsDefault,
   parameter int unsigned WIN_CNT_WIDTH = 16
) (
   input logic               clk,
   input logic               rstN,
   accum_window_ctrl_if.slave bus
);

   localparam int unsigned TapW = $clog2(TAPS + 1);

   state_e                   state_q, state_d;
   logic [TapW-1:0]          tap_cnt_q, tap_cnt_d;
   logic [WIN_CNT_WIDTH-1:0] win_idx_q, win_idx_d;
   logic [WIN_CNT_WIDTH-1:0] num_win_q, num_win_d;
   logic                     acc_clr;
   logic                     acc_en;
   logic [ACC_WIDTH-1:0]     psum;

   assign acc_en = (state_q == StAccum) && bus.din_valid;

   always_comb begin
      state_d   = state_q;
      tap_cnt_d = tap_cnt_q;
      win_idx_d = win_idx_q;
      num_win_d = num_win_q;
      acc_clr   = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.num_windows != '0) begin
                  num_win_d = bus.num_windows;
                  tap_cnt_d = '0;
                  win_idx_d = '0;
                  acc_clr   = 1'b1;
                  state_d   = StAccum;
               end else begin
                  state_d = StFin;
               end
            end
         end
         StAccum: begin
            if (bus.din_valid) begin
               tap_cnt_d = tap_cnt_q + TapW'(1);
               if (tap_cnt_q == TapW'(TAPS - 1)) begin
                  state_d = StOut;
               end
            end
         end
         StOut: begin
            if (bus.dout_ready) begin
               tap_cnt_d = '0;
               acc_clr   = 1'b1;
               if (win_idx_q == (num_win_q - WIN_CNT_WIDTH'(1))) begin
                  state_d = StFin;
               end else begin
                  win_idx_d = win_idx_q + WIN_CNT_WIDTH'(1);
                  state_d   = StAccum;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= StIdle;
         tap_cnt_q <= '0;
         win_idx_q <= '0;
         num_win_q <= '0;
      end else begin
         state_q   <= state_d;
         tap_cnt_q <= tap_cnt_d;
         win_idx_q <= win_idx_d;
         num_win_q <= num_win_d;
      end
   end

   accum_datapath #(
      .DATA_BITWIDTH(DATA_BITWIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
   ) u_datapath (
      .clk (clk),
      .rstN(rstN),
      .clr (acc_clr),
      .en  (acc_en),
      .din (bus.din),
      .psum(psum)
   );

   // All status outputs decode the registered state, so they are glitch-free and reset to 0.
   assign bus.busy       = (state_q == StAccum) || (state_q == StOut);
   assign bus.done       = (state_q == StFin);
   assign bus.din_ready  = (state_q == StAccum);
   assign bus.dout_valid = (state_q == StOut);
   assign bus.dout       = psum;
   assign bus.win_idx    = win_idx_q;

endmodule

// File: tb/tb_accum_window_ctrl.sv
// Directed bench for accum_window_ctrl (ACC_WIDTH=10 so the wrap/saturate case is reachable).
module tb_accum_window_ctrl;

   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 10;
   localparam int unsigned WW  = 16;

`ifdef ACC_SATURATE_EN
   localparam logic [63:0] OvfExp = 64'd1023;
`else
   localparam logic [63:0] OvfExp = 64'd247;
`endif

   logic clk;
   logic rstN;
   int   n_total;
   int   n_bad;

   accum_window_ctrl_if #(.DATA_BITWIDTH(DW), .ACC_WIDTH(AW), .WIN_CNT_WIDTH(WW)) bus ();

   accum_window_ctrl #(
      .DATA_BITWIDTH(DW),
      .ACC_WIDTH    (AW),
      .TAPS         (9),
      .WIN_CNT_WIDTH(WW)
   ) dut (
      .clk (clk),
      .rstN(rstN),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int unsigned n);
      bus.start       = 1'b1;
      bus.num_windows = WW'(n);
      step();
      bus.start = 1'b0;
   endtask

   task automatic feed(input int unsigned v, input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         bus.din       = DW'(v);
         bus.din_valid = 1'b1;
         step();
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
      check({tag, "_drdy"}, 64'(bus.din_ready), 64'd0);
      check({tag, "_dout"}, 64'(bus.dout), 64'd0);
      check({tag, "_dval"}, 64'(bus.dout_valid), 64'd0);
      check({tag, "_widx"}, 64'(bus.win_idx), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pat [15];
      pat = '{1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
      n_total         = 0;
      n_bad           = 0;
      rstN            = 1'b0;
      bus.start       = 1'b0;
      bus.num_windows = '0;
      bus.din         = '0;
      bus.din_valid   = 1'b0;
      bus.dout_ready  = 1'b0;
      repeat (2) step();
      check_reset_outputs("rst");
      rstN = 1'b1;
      step();

      // Basic window: 1..9 -> 45
      bus.dout_ready = 1'b1;
      start_job(1);
      check("b_busy", 64'(bus.busy), 64'd1);
      check("b_drdy", 64'(bus.din_ready), 64'd1);
      for (int i = 1; i <= 9; i++) begin
         check("b_noval", 64'(bus.dout_valid), 64'd0);
         bus.din       = DW'(i);
         bus.din_valid = 1'b1;
         step();
      end
      bus.din_valid = 1'b0;
      check("b_dval", 64'(bus.dout_valid), 64'd1);
      check("b_dout", 64'(bus.dout), 64'd45);
      check("b_out_drdy", 64'(bus.din_ready), 64'd0);
      step();
      check("b_done", 64'(bus.done), 64'd1);
      check("b_busy_fin", 64'(bus.busy), 64'd0);
      check("b_dval_fin", 64'(bus.dout_valid), 64'd0);
      step();
      check("b_done_pulse", 64'(bus.done), 64'd0);

      // Three windows of 10x9 with 5-cycle backpressure, stray start mid-job
      bus.dout_ready = 1'b0;
      start_job(3);
      for (int w = 0; w < 3; w++) begin
         feed(10, 9);
         check("m_dout", 64'(bus.dout), 64'd90);
         check("m_widx", 64'(bus.win_idx), 64'(w));
         for (int k = 0; k < 5; k++) begin
            bus.din       = DW'(50);
            bus.din_valid = 1'b1;
            if (w == 1 && k == 0) begin
               bus.start       = 1'b1;
               bus.num_windows = WW'(5);
            end
            step();
            bus.start     = 1'b0;
            bus.din_valid = 1'b0;
            check("m_stall_dout", 64'(bus.dout), 64'd90);
            check("m_stall_dval", 64'(bus.dout_valid), 64'd1);
            check("m_stall_drdy", 64'(bus.din_ready), 64'd0);
         end
         bus.dout_ready = 1'b1;
         step();
         bus.dout_ready = 1'b0;
         if (w < 2) begin
            check("m_next_widx", 64'(bus.win_idx), 64'(w + 1));
            check("m_next_drdy", 64'(bus.din_ready), 64'd1);
            check("m_next_dval", 64'(bus.dout_valid), 64'd0);
         end else begin
            check("m_done", 64'(bus.done), 64'd1);
         end
      end
      step();
      check("m_idle_busy", 64'(bus.busy), 64'd0);

      // Input gaps: only valid beats of 2 count, invalid slots carry 7
      bus.dout_ready = 1'b1;
      start_job(1);
      for (int k = 0; k < 15; k++) begin
         check("g_drdy", 64'(bus.din_ready), 64'd1);
         bus.din       = (pat[k] == 1) ? DW'(2) : DW'(7);
         bus.din_valid = (pat[k] == 1);
         step();
      end
      bus.din_valid = 1'b0;
      check("g_dval", 64'(bus.dout_valid), 64'd1);
      check("g_dout", 64'(bus.dout), 64'd18);
      step();
      check("g_done", 64'(bus.done), 64'd1);
      step();

      // Zero windows: straight to done, no output beat
      start_job(0);
      check("z_done", 64'(bus.done), 64'd1);
      check("z_busy", 64'(bus.busy), 64'd0);
      check("z_dval", 64'(bus.dout_valid), 64'd0);
      step();
      check("z_done_pulse", 64'(bus.done), 64'd0);

      // Reset after 4 beats of window 1, then a clean job
      start_job(2);
      feed(5, 9);
      check("r_w0_dout", 64'(bus.dout), 64'd45);
      step();
      check("r_w1_widx", 64'(bus.win_idx), 64'd1);
      feed(5, 4);
      #2;
      rstN = 1'b0;
      #1;
      check_reset_outputs("r_mid");
      #3;
      rstN = 1'b1;
      step();
      check_reset_outputs("r_after");
      start_job(1);
      feed(3, 9);
      check("r_new_dout", 64'(bus.dout), 64'd27);
      step();
      check("r_new_done", 64'(bus.done), 64'd1);
      step();

      // Overflow of the 10-bit accumulator: 255x9 = 2295
      start_job(1);
      feed(255, 9);
      check("o_dval", 64'(bus.dout_valid), 64'd1);
      check("o_dout", 64'(bus.dout), OvfExp);
      step();
      check("o_done", 64'(bus.done), 64'd1);
      step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
